// File: rtl/alarm_ctrl.sv
// alarm_ctrl: multi-zone alarm controller with exit/entry delays and zone latching.
// Five-state arming sequence (DISARMED, EXIT, ARMED, ENTRY, ALARM) clocked on Clk2.
// The state code is exposed on digit for the 7-segment decoder and for checkers.
// Optional feature macro: ALARM_CTRL_LOCKOUT_EN builds a wrong-code counter that
// forces ALARM after MAX_FAILS bad codes while EXIT, ARMED or ENTRY.
//
// Handshake: arm_p and disarm_p are single-cycle pulses with no backpressure; a
// pulse is consumed at the Clk2 edge where it is high, and code_in is only
// meaningful at that same edge.
module alarm_ctrl #(
   parameter int             ZONES       = 4,
   parameter int             CODE_W      = 4,
   parameter bit [CODE_W-1:0] CODE       = 4'b0001,
   parameter int             EXIT_TICKS  = 8,
   parameter int             ENTRY_TICKS = 8,
   parameter int             MAX_FAILS   = 3
) (
   input  logic              Clk2,
   input  logic              reset,
   input  logic              arm_p,
   input  logic              disarm_p,
   input  logic [CODE_W-1:0] code_in,
   input  logic [ZONES-1:0]  zone,
   output logic              Led,
   output logic              armed_led,
   output logic [ZONES-1:0]  zone_latch,
   output logic [3:0]        digit
);

   localparam int MAX_T = (EXIT_TICKS > ENTRY_TICKS) ? EXIT_TICKS : ENTRY_TICKS;
   localparam int TW    = ($clog2(MAX_T) < 1) ? 1 : $clog2(MAX_T);
   localparam logic [TW-1:0] EXIT_LOAD  = TW'(EXIT_TICKS - 1);
   localparam logic [TW-1:0] ENTRY_LOAD = TW'(ENTRY_TICKS - 1);

   // Reject parameter sets the counters and ports cannot represent.
   if (ZONES < 1 || ZONES > 8) begin : g_bad_zones
      $error("alarm_ctrl: ZONES must be 1..8");
   end
   if (MAX_FAILS < 1 || MAX_FAILS > 3) begin : g_bad_fails
      $error("alarm_ctrl: MAX_FAILS must be 1..3 for the 2-bit fail counter");
   end
   if (EXIT_TICKS < 1 || ENTRY_TICKS < 1) begin : g_bad_ticks
      $error("alarm_ctrl: delays must be at least one cycle");
   end

   typedef enum logic [2:0] {
      S_DISARMED = 3'd0,
      S_EXIT     = 3'd1,
      S_ARMED    = 3'd2,
      S_ENTRY    = 3'd3,
      S_ALARM    = 3'd4
   } state_t;

   state_t           state, state_nx;
   logic [TW-1:0]    timer, timer_nx;
   logic [ZONES-1:0] zsync1, zs;
   logic [ZONES-1:0] latch_q, latch_nx;
   logic             ok;
   logic             zone_hit;
   logic             arm_go;
   logic             guarded;
   logic             lock_trip;

   assign ok       = disarm_p & (code_in == CODE);
   assign zone_hit = |zs;
   assign guarded  = (state == S_EXIT) | (state == S_ARMED) | (state == S_ENTRY);
   // disarm_p in the same cycle cancels an arm request.
   assign arm_go   = (state == S_DISARMED) & arm_p & ~disarm_p & ~zone_hit;

   // Two-flop synchroniser for the asynchronous sensor lines.
   always_ff @(posedge Clk2 or negedge reset) begin
      if (!reset) begin
         zsync1 <= '0;
         zs     <= '0;
      end else begin
         zsync1 <= zone;
         zs     <= zsync1;
      end
   end

`ifdef ALARM_CTRL_LOCKOUT_EN
   logic [1:0] fail_q, fail_nx, fail_inc;
   logic       bad;

   assign bad      = disarm_p & ~ok;
   assign fail_inc = (fail_q == 2'd3) ? fail_q : fail_q + 2'd1;

   // Wrong-code counter: counts bad codes only while the system is arming or armed.
   always_comb begin
      fail_nx   = fail_q;
      lock_trip = 1'b0;
      if (ok || arm_go) begin
         fail_nx = 2'd0;
      end else if (guarded && bad) begin
         fail_nx   = fail_inc;
         lock_trip = (int'(fail_inc) >= MAX_FAILS);
      end
   end

   // Fail counter register.
   always_ff @(posedge Clk2 or negedge reset) begin
      if (!reset) fail_q <= 2'd0;
      else        fail_q <= fail_nx;
   end
`else
   assign lock_trip = 1'b0;
`endif

   // State, delay timer and zone latch registers.
   always_ff @(posedge Clk2 or negedge reset) begin
      if (!reset) begin
         state   <= S_DISARMED;
         timer   <= '0;
         latch_q <= '0;
      end else begin
         state   <= state_nx;
         timer   <= timer_nx;
         latch_q <= latch_nx;
      end
   end

   // Next-state logic: a valid code wins, then lockout, then timer and zone events.
   always_comb begin
      state_nx = state;
      timer_nx = timer;
      latch_nx = latch_q;
      if (state == S_ENTRY || state == S_ALARM) begin
         latch_nx = latch_q | zs;
      end
      case (state)
         S_DISARMED: begin
            if (arm_go) begin
               state_nx = S_EXIT;
               timer_nx = EXIT_LOAD;
               latch_nx = '0;
            end
         end
         S_EXIT: begin
            if (ok)                  state_nx = S_DISARMED;
            else if (lock_trip)      state_nx = S_ALARM;
            else if (timer == '0)    state_nx = S_ARMED;
            else                     timer_nx = timer - 1'b1;
         end
         S_ARMED: begin
            if (ok) begin
               state_nx = S_DISARMED;
            end else if (lock_trip) begin
               state_nx = S_ALARM;
            end else if (zone_hit) begin
               state_nx = S_ENTRY;
               timer_nx = ENTRY_LOAD;
               latch_nx = latch_q | zs;
            end
         end
         S_ENTRY: begin
            if (ok)                  state_nx = S_DISARMED;
            else if (lock_trip)      state_nx = S_ALARM;
            else if (timer == '0)    state_nx = S_ALARM;
            else                     timer_nx = timer - 1'b1;
         end
         S_ALARM: begin
            if (ok) state_nx = S_DISARMED;
         end
         default: begin
            state_nx = S_DISARMED;
            timer_nx = '0;
         end
      endcase
   end

   assign Led        = (state == S_ALARM);
   assign armed_led  = guarded;
   assign zone_latch = latch_q;
   assign digit      = {1'b0, state};

endmodule

// File: tb/tb_alarm_ctrl.sv
// tb_alarm_ctrl: directed test-plan steps followed by randomized traffic, every
// cycle compared against a cycle-count/deadline reference model of the controller.
module tb_alarm_ctrl;

   localparam int         ZONES = 4;
   localparam logic [3:0] CODE  = 4'b0001;
   localparam int         ET    = 8;
   localparam int         NT    = 8;
   localparam int         MAXF  = 3;
`ifdef ALARM_CTRL_LOCKOUT_EN
   localparam bit LOCK = 1'b1;
`else
   localparam bit LOCK = 1'b0;
`endif

   logic       Clk2     = 1'b0;
   logic       reset    = 1'b0;
   logic       arm_p    = 1'b0;
   logic       disarm_p = 1'b0;
   logic [3:0] code_in  = 4'd0;
   logic [3:0] zone     = 4'd0;
   logic       Led;
   logic       armed_led;
   logic [3:0] zone_latch;
   logic [3:0] digit;

   int checks = 0;
   int errors = 0;

   // reference model: state number, edge count, deadline edge, latched zones
   int         m_state    = 0;
   int         m_cyc      = 0;
   int         m_deadline = 0;
   int         m_fails    = 0;
   logic [3:0] m_latch    = 4'd0;
   logic [3:0] zh0        = 4'd0;
   logic [3:0] zh1        = 4'd0;

   always #5 Clk2 = ~Clk2;

   alarm_ctrl #(
      .ZONES(ZONES), .CODE_W(4), .CODE(CODE),
      .EXIT_TICKS(ET), .ENTRY_TICKS(NT), .MAX_FAILS(MAXF)
   ) dut (
      .Clk2(Clk2), .reset(reset), .arm_p(arm_p), .disarm_p(disarm_p),
      .code_in(code_in), .zone(zone), .Led(Led), .armed_led(armed_led),
      .zone_latch(zone_latch), .digit(digit)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic compare_all(input string tag);
      chk({tag, "_digit"}, {4'd0, digit}, 8'(m_state));
      chk({tag, "_led"}, {7'd0, Led}, {7'd0, m_state == 4});
      chk({tag, "_armed"}, {7'd0, armed_led}, {7'd0, m_state >= 1 && m_state <= 3});
      chk({tag, "_latch"}, {4'd0, zone_latch}, {4'd0, m_latch});
   endtask

   task automatic model_reset();
      m_state = 0; m_fails = 0; m_latch = 4'd0; zh0 = 4'd0; zh1 = 4'd0;
   endtask

   // One clock edge of the reference model, from the rules of the alarm sequence.
   task automatic model_edge(input logic a, input logic d, input logic [3:0] c,
                             input logic [3:0] z);
      logic       ok, bad, trip;
      logic [3:0] zsv;
      ok  = d && (c == CODE);
      bad = d && !ok;
      zsv = zh1;          // sensors reach the decision logic two edges late
      zh1 = zh0;
      zh0 = z;
      m_cyc++;
      trip = 1'b0;
      if (LOCK && m_state >= 1 && m_state <= 3 && bad) begin
         m_fails = (m_fails < 3) ? m_fails + 1 : 3;
         trip    = (m_fails >= MAXF);
      end
      if (ok) m_fails = 0;
      if (m_state == 3 || m_state == 4) m_latch = m_latch | zsv;
      if (m_state != 0 && ok) m_state = 0;
      else if (trip) m_state = 4;
      else begin
         case (m_state)
            0: if (a && !d && zsv == 4'd0) begin
                  m_state = 1; m_deadline = m_cyc + ET; m_latch = 4'd0; m_fails = 0;
               end
            1: if (m_cyc >= m_deadline) m_state = 2;
            2: if (zsv != 4'd0) begin
                  m_state = 3; m_deadline = m_cyc + NT; m_latch = m_latch | zsv;
               end
            3: if (m_cyc >= m_deadline) m_state = 4;
            default: ;
         endcase
      end
   endtask

   // Drive one cycle of inputs (called at a negedge), clock it, and compare.
   task automatic step(input logic a, input logic d, input logic [3:0] c, input logic [3:0] z);
      arm_p = a; disarm_p = d; code_in = c; zone = z;
      @(posedge Clk2);
      model_edge(a, d, c, z);
      #1;
      compare_all("cyc");
      @(negedge Clk2);
      arm_p = 1'b0; disarm_p = 1'b0;
   endtask

   task automatic idle(input int n, input logic [3:0] z);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, z);
   endtask

   task automatic hard_reset();
      reset = 1'b0;
      #1;
      model_reset();
      compare_all("rst");
      repeat (2) @(negedge Clk2);
      reset = 1'b1;
   endtask

   initial begin
      int         ex;
      logic       a, d;
      logic [3:0] c, z;

      @(negedge Clk2);
      hard_reset();

      // arm with zones clear: EXIT for exactly ET cycles, then ARMED
      step(1'b1, 1'b0, 4'd0, 4'd0);
      chk("arm_exit_digit", {4'd0, digit}, 8'd1);
      chk("arm_exit_led", {7'd0, armed_led}, 8'd1);
      ex = 1;
      for (int i = 0; i < 12; i++) begin
         step(1'b0, 1'b0, 4'd0, 4'd0);
         if (digit == 4'd1) ex++;
         else break;
      end
      chk("exit_len", 8'(ex), 8'(ET));
      chk("armed_digit", {4'd0, digit}, 8'd2);
      step(1'b0, 1'b1, CODE, 4'd0);
      chk("disarm_digit", {4'd0, digit}, 8'd0);

      // arm refused while a zone is active
      idle(3, 4'b0010);
      step(1'b1, 1'b0, 4'd0, 4'b0010);
      chk("arm_blocked", {4'd0, digit}, 8'd0);
      idle(3, 4'd0);

      // zone[2] pulse in ARMED: ENTRY two cycles later, ALARM after NT cycles
      step(1'b1, 1'b0, 4'd0, 4'd0);
      idle(ET, 4'd0);
      chk("armed2", {4'd0, digit}, 8'd2);
      step(1'b0, 1'b0, 4'd0, 4'b0100);
      step(1'b0, 1'b0, 4'd0, 4'd0);
      chk("zone_lat1", {4'd0, digit}, 8'd2);
      step(1'b0, 1'b0, 4'd0, 4'd0);
      chk("zone_lat2", {4'd0, digit}, 8'd3);
      idle(NT - 1, 4'd0);
      chk("entry_end", {4'd0, digit}, 8'd3);
      idle(1, 4'd0);
      chk("alarm_digit", {4'd0, digit}, 8'd4);
      chk("alarm_led", {7'd0, Led}, 8'd1);
      chk("alarm_latch", {4'd0, zone_latch}, 8'h04);

      // ALARM with arm and valid disarm together: disarm only
      step(1'b1, 1'b1, CODE, 4'd0);
      chk("alarm_off", {4'd0, digit}, 8'd0);
      chk("alarm_off_led", {7'd0, Led}, 8'd0);
      idle(1, 4'd0);
      chk("no_rearm", {4'd0, digit}, 8'd0);
      chk("latch_held", {4'd0, zone_latch}, 8'h04);

      // valid disarm in the last ENTRY cycle beats expiry
      step(1'b1, 1'b0, 4'd0, 4'd0);
      chk("latch_clr", {4'd0, zone_latch}, 8'h00);
      idle(ET, 4'd0);
      step(1'b0, 1'b0, 4'd0, 4'b0001);
      idle(2, 4'd0);
      chk("entry2", {4'd0, digit}, 8'd3);
      idle(NT - 1, 4'd0);
      chk("entry_t0", {4'd0, digit}, 8'd3);
      step(1'b0, 1'b1, CODE, 4'd0);
      chk("late_ok", {4'd0, digit}, 8'd0);
      chk("late_ok_led", {7'd0, Led}, 8'd0);
      idle(2, 4'd0);
      chk("late_latch", {4'd0, zone_latch}, 8'h01);

      // three wrong codes in ARMED
      step(1'b1, 1'b0, 4'd0, 4'd0);
      idle(ET, 4'd0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'b0111, 4'd0);
      chk("bad_codes", {4'd0, digit}, LOCK ? 8'd4 : 8'd2);
      step(1'b0, 1'b1, CODE, 4'd0);

      // reset mid EXIT aborts at once, without a clock edge
      step(1'b1, 1'b0, 4'd0, 4'd0);
      idle(3, 4'd0);
      chk("pre_rst", {4'd0, digit}, 8'd1);
      #2 reset = 1'b0;
      #1;
      model_reset();
      compare_all("mid_rst");
      @(negedge Clk2);
      reset = 1'b1;

      // randomized traffic against the model
      z = 4'd0;
      for (int i = 0; i < 3000; i++) begin
         a = ($urandom_range(0, 7) == 0);
         d = ($urandom_range(0, 15) == 0);
         c = ($urandom_range(0, 1) == 0) ? CODE : 4'($urandom_range(0, 15));
         if (z != 4'd0) begin
            if ($urandom_range(0, 2) == 0) z = 4'd0;
         end else if ($urandom_range(0, 39) == 0) begin
            z = 4'($urandom_range(1, 15));
         end
         step(a, d, c, z);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alarm_ctrl.md
# alarm_ctrl

Multi-zone alarm controller: the parametrised successor to the single-LED armed/disarmed alarm FSM. Takes debounced, edge-detected arm/disarm pulses, a keyed code and `ZONES` raw sensor lines. Runs a five-state arming sequence with exit and entry delays and latches which zones tripped. Drives the alarm LED, an armed LED and a 4-bit state digit for the existing 7-segment decoder. Sits between the debounce/edge-detect front end and the display path, clocked on the divided clock.

## Interface
Parameters:
- `ZONES`, 4: number of sensor zones (1..8).
- `CODE_W`, 4: disarm code width.
- `CODE`, 4'b0001: valid disarm code.
- `EXIT_TICKS`, 8: exit-delay length in Clk2 cycles (≥1).
- `ENTRY_TICKS`, 8: entry-delay length in Clk2 cycles (≥1).
- `MAX_FAILS`, 3: wrong-code attempts that force ALARM (lockout build only).

Ports:
- `Clk2` in 1: block clock.
- `reset` in 1: reset, asynchronous, active-low.
- `arm_p` in 1: single-cycle arm request pulse.
- `disarm_p` in 1: single-cycle disarm request pulse, qualified by `code_in`.
- `code_in` in CODE_W: code sampled on `disarm_p`.
- `zone` in ZONES: raw asynchronous sensor levels, active-high.
- `Led` out 1: alarm sounding.
- `armed_led` out 1: high in EXIT, ARMED and ENTRY.
- `zone_latch` out ZONES: zones that tripped since the last arm.
- `digit` out 4: state code for the 7-segment decoder.

## Operation
- `zone` passes through a 2-FF synchroniser, giving `zs`. Every FSM decision uses `zs`.
- `ok = disarm_p & (code_in == CODE)`. `bad = disarm_p & ~ok`.
- State codes on `digit`: DISARMED=0, EXIT=1, ARMED=2, ENTRY=3, ALARM=4.
- DISARMED:
  - `arm_p` with `zs == 0` → EXIT. Timer loads EXIT_TICKS-1 and `zone_latch` clears.
  - `arm_p` with any `zs` set is ignored.
- EXIT:
  - `ok` → DISARMED.
  - Otherwise timer == 0 → ARMED; else the timer decrements.
  - Zones are ignored.
- ARMED:
  - `ok` → DISARMED.
  - Otherwise any `zs` set → ENTRY. Timer loads ENTRY_TICKS-1 and `zone_latch |= zs`.
- ENTRY:
  - `ok` → DISARMED.
  - Otherwise timer == 0 → ALARM; else the timer decrements.
  - `zone_latch |= zs` every cycle.
- ALARM:
  - `ok` → DISARMED.
  - `zone_latch |= zs` every cycle.
- Precedence within one cycle:
  - `ok` beats timer expiry and zone trip.
  - `disarm_p` beats `arm_p`. In DISARMED, `arm_p` together with `disarm_p` does nothing.
- `arm_p` outside DISARMED is ignored.
- `zone_latch` holds through DISARMED. It clears only on the DISARMED→EXIT transition.
- Timer width is `$clog2(max(EXIT_TICKS, ENTRY_TICKS))`, minimum 1 bit. The timer never wraps: it stops at 0.
- Outputs are decoded from registered state with no additional combinational input paths: `Led = (state==ALARM)`.

## Timing
- Reset (async assert, sync release by the system) forces:
  - state DISARMED, timer 0, synchroniser 0, fail counter 0.
  - `Led`=0, `armed_led`=0, `zone_latch`=0, `digit`=0.
- Zone latency: `zone` rising before edge n makes ENTRY visible after edge n+2.
- Exit delay: the state is EXIT for exactly EXIT_TICKS cycles after the `arm_p` edge, then ARMED.
- Entry delay: the state is ENTRY for exactly ENTRY_TICKS cycles, then ALARM.
- `ok` takes effect at the next edge, from any non-DISARMED state.
- A reset asserted mid-delay or in ALARM aborts immediately. No state survives.

## Configuration
- `ALARM_CTRL_LOCKOUT_EN` defined:
  - A 2-bit fail counter increments on `bad` in EXIT, ARMED or ENTRY.
  - When the counter reaches MAX_FAILS, the next state is ALARM, overriding timer and zone transitions.
  - The counter clears on `ok` and on the DISARMED→EXIT transition.
  - `bad` in DISARMED or ALARM is ignored by the counter.
- Not defined:
  - No counter is built and `bad` pulses have no effect.
  - MAX_FAILS is unused.

## Test plan
- Reset, then `arm_p` with zones clear → `digit`=1, `armed_led`=1 for 8 cycles, then `digit`=2. `arm_p` with `zone`=4'b0010 → stays `digit`=0.
- ARMED, `zone[2]` pulses → `digit`=3 two cycles later. No disarm → `digit`=4, `Led`=1 after 8 cycles, `zone_latch`=4'b0100.
- ENTRY with timer at 0, `disarm_p` with `code_in`=4'b0001 in the same cycle → `digit`=0, `Led`=0. `zone_latch` is held until the next arm.
- ARMED, three `disarm_p` with `code_in`=4'b0111 → with `ALARM_CTRL_LOCKOUT_EN`, `digit`=4 after the third; without it, `digit` stays 2.
- ALARM, `arm_p` and `disarm_p` with `CODE` together → DISARMED, no re-arm. `reset` low during EXIT → all outputs 0 immediately.
